// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide sequencer for the uDLX execute stage.
// One shift-add (multiply) or restoring-subtract (divide) step per cycle.
//
// Build option: define MULDIV_SIGNED_EN to honour op_signed (two's-complement
// operands). Without it every operation is unsigned and op_signed is ignored.
//
// Ports:
//   clk, rst_n              core clock, asynchronous active-low reset
//   op_valid/op_ready       request handshake (op_ready high only in IDLE)
//   op_div, op_signed       1 = divide / 0 = multiply; signed operand mode
//   op_a, op_b              multiplicand/dividend, multiplier/divisor
//   res_valid/res_ready     result handshake (res_valid high only in DONE)
//   res_lo, res_hi          product low/high word, or quotient/remainder
//   div_by_zero             last division had op_b == 0 (valid with res_valid)
//   stall                   high in CALC, FIX, DONE
//
// state | meaning
// IDLE  | waiting for an op, op_ready=1
// CALC  | one iteration per cycle, count 0..DATA_WIDTH-1
// FIX   | sign correction / divide-by-zero override
// DONE  | result held, res_valid=1 until res_ready
module muldiv_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic                  op_div,
    input  logic                  op_signed,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_lo,
    output logic [DATA_WIDTH-1:0] res_hi,
    output logic                  div_by_zero,
    output logic                  stall
);
    localparam int W = DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(W - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] count;
    logic [W-1:0]         a_mag;
    logic [W-1:0]         b_mag;
    logic                 is_div;
    logic                 b_zero;

    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         sign_a_in;
    logic         sign_b_in;
    logic         sign_a;
    logic         sign_b;

`ifdef MULDIV_SIGNED_EN
    assign sign_a_in = op_signed & op_a[W-1];
    assign sign_b_in = op_signed & op_b[W-1];
    assign a_in      = sign_a_in ? -op_a : op_a;
    assign b_in      = sign_b_in ? -op_b : op_b;
`else
    logic unused_op_signed;
    assign unused_op_signed = op_signed;
    assign sign_a_in = 1'b0;
    assign sign_b_in = 1'b0;
    assign a_in      = op_a;
    assign b_in      = op_b;
`endif

    // Multiply: res_lo holds the remaining multiplier bits, res_hi the upper
    // partial product; the W+1 bit sum keeps the carry that shifts down.
    logic [W:0] mul_sum;
    assign mul_sum = {1'b0, res_hi} + (res_lo[0] ? {1'b0, a_mag} : '0);

    // Divide: shift the next dividend bit (res_lo MSB) into the remainder.
    // When the subtraction succeeds the difference always fits in W bits.
    logic [W:0]   div_shift;
    logic         div_ge;
    logic [W-1:0] div_sub;
    assign div_shift = {res_hi, res_lo[W-1]};
    assign div_ge    = div_shift >= {1'b0, b_mag};
    assign div_sub   = div_shift[W-1:0] - b_mag;

    // Original dividend, rebuilt from its magnitude for the /0 override.
    logic [W-1:0] a_orig;
    assign a_orig = sign_a ? -a_mag : a_mag;

    logic [W-1:0]   fix_lo;
    logic [W-1:0]   fix_hi;
    logic [2*W-1:0] prod_neg;
    assign prod_neg = -{res_hi, res_lo};

    always_comb begin
        fix_lo = res_lo;
        fix_hi = res_hi;
        if (is_div && b_zero) begin
            fix_lo = '1;
            fix_hi = a_orig;
        end else if (is_div) begin
            if (sign_a ^ sign_b) fix_lo = -res_lo;
            if (sign_a)          fix_hi = -res_hi;
        end else if (sign_a ^ sign_b) begin
            {fix_hi, fix_lo} = prod_neg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            count       <= '0;
            a_mag       <= '0;
            b_mag       <= '0;
            is_div      <= 1'b0;
            b_zero      <= 1'b0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            res_lo      <= '0;
            res_hi      <= '0;
            div_by_zero <= 1'b0;
            op_ready    <= 1'b1;
            res_valid   <= 1'b0;
            stall       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        a_mag       <= a_in;
                        b_mag       <= b_in;
                        is_div      <= op_div;
                        b_zero      <= (op_b == '0);
                        sign_a      <= sign_a_in;
                        sign_b      <= sign_b_in;
                        res_hi      <= '0;
                        res_lo      <= op_div ? a_in : b_in;
                        count       <= '0;
                        div_by_zero <= 1'b0;
                        op_ready    <= 1'b0;
                        stall       <= 1'b1;
                        state       <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (is_div) begin
                        res_hi <= div_ge ? div_sub : div_shift[W-1:0];
                        res_lo <= {res_lo[W-2:0], div_ge};
                    end else begin
                        res_hi <= mul_sum[W:1];
                        res_lo <= {mul_sum[0], res_lo[W-1:1]};
                    end
                    count <= count + CNT_WIDTH'(1);
                    if (count == LAST_CNT) state <= S_FIX;
                end
                S_FIX: begin
                    res_lo      <= fix_lo;
                    res_hi      <= fix_hi;
                    div_by_zero <= is_div & b_zero;
                    res_valid   <= 1'b1;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        stall     <= 1'b0;
                        op_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Testbench for muldiv_seq: directed cases with literal results plus random
// operations checked against an arithmetic reference model.
module tb_muldiv_seq;
    localparam int DW = 32;
`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic          op_div = 1'b0;
    logic          op_signed = 1'b0;
    logic [DW-1:0] op_a = '0;
    logic [DW-1:0] op_b = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [DW-1:0] res_lo;
    logic [DW-1:0] res_hi;
    logic          div_by_zero;
    logic          stall;

    muldiv_seq #(.DATA_WIDTH(DW), .CNT_WIDTH(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_div(op_div), .op_signed(op_signed),
        .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_lo(res_lo), .res_hi(res_hi),
        .div_by_zero(div_by_zero), .stall(stall)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] exp_lo, exp_hi;
    logic          exp_dbz;
    logic          exp_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, req);
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic void model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  input logic div, input logic sgn,
                                  output logic [DW-1:0] lo, output logic [DW-1:0] hi,
                                  output logic dbz);
        logic [63:0] p;
        longint      sa, sb, q, r;
        dbz = 1'b0;
        lo  = '0;
        hi  = '0;
        if (div && b == 0) begin
            lo  = '1;
            hi  = a;
            dbz = 1'b1;
        end else if (!(sgn && SIGNED_EN)) begin
            if (div) begin
                lo = a / b;
                hi = a % b;
            end else begin
                p = {32'b0, a} * {32'b0, b};
                {hi, lo} = p;
            end
        end else begin
            sa = $signed(a);
            sb = $signed(b);
            if (div) begin
                q  = sa / sb;
                r  = sa % sb;
                lo = q[31:0];
                hi = r[31:0];
            end else begin
                p = sa * sb;
                {hi, lo} = p;
            end
        end
    endfunction

    // Result checker: every DONE cycle must show the modelled result.
    always @(negedge clk) begin
        if (rst_n && exp_valid && res_valid === 1'b1) begin
            chk("res_lo", res_lo, exp_lo);
            chk("res_hi", res_hi, exp_hi);
            chk("div_by_zero", div_by_zero, exp_dbz);
            chk("done_ready_stall", {op_ready, stall}, 2'b01);
        end
    end

    task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic div, input logic sgn, input int bp,
                         output logic [DW-1:0] got_lo, output logic [DW-1:0] got_hi,
                         output logic got_dbz);
        int lat;
        bit ok;
        bit accepted;
        got_lo  = 'x;
        got_hi  = 'x;
        got_dbz = 1'bx;
        model(a, b, div, sgn, exp_lo, exp_hi, exp_dbz);
        exp_valid = 1'b1;
        @(negedge clk);
        op_valid  = 1'b1;
        op_a      = a;
        op_b      = b;
        op_div    = div;
        op_signed = sgn;
        res_ready = (bp == 0);
        accepted  = 1'b0;
        for (int i = 0; i < 10 && !accepted; i++) begin
            if (op_ready === 1'b1) accepted = 1'b1;
            else @(negedge clk);
        end
        chk("accept", accepted, 1);
        if (!accepted) begin
            op_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 op_valid = 1'b0;
        lat = 0;
        ok  = 1'b1;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (stall !== 1'b1) ok = 1'b0;
            if (res_valid === 1'b1) break;
            // Inputs after accept must not influence the result.
            op_a      = $urandom;
            op_b      = $urandom;
            op_div    = 1'($urandom_range(0, 1));
            op_signed = 1'($urandom_range(0, 1));
        end
        chk("latency", lat, DW + 2);
        chk("stall_busy", ok, 1);
        got_lo  = res_lo;
        got_hi  = res_hi;
        got_dbz = div_by_zero;
        for (int i = 0; i < bp; i++) begin
            chk("hold_ready", op_ready, 0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("release", {res_valid, op_ready, stall}, 3'b010);
    endtask

    logic [DW-1:0] lo, hi;
    logic          dbz;

    initial begin
        #1_000_000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_flags", {op_ready, res_valid, stall, div_by_zero}, 4'b1000);
        chk("rst_res", {res_hi, res_lo}, 64'h0);
        rst_n = 1'b1;

        do_op(32'd7, 32'd6, 1'b0, 1'b0, 0, lo, hi, dbz);
        chk("mul_7x6", {hi, lo}, 64'd42);
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 0, lo, hi, dbz);
        chk("mul_max", {hi, lo}, 64'hFFFFFFFE_00000001);
        do_op(32'd100, 32'd7, 1'b1, 1'b0, 0, lo, hi, dbz);
        chk("div_100_7", {dbz, hi, lo}, {1'b0, 32'd2, 32'd14});
        do_op(32'h1234, 32'd0, 1'b1, 1'b0, 5, lo, hi, dbz);
        chk("div_zero", {dbz, hi, lo}, {1'b1, 32'h1234, 32'hFFFFFFFF});
        do_op(32'd9, 32'd4, 1'b1, 1'b0, 3, lo, hi, dbz);
        chk("dbz_cleared", {dbz, hi, lo}, {1'b0, 32'd1, 32'd2});
`ifdef MULDIV_SIGNED_EN
        do_op(-32'sd7, 32'd2, 1'b1, 1'b1, 0, lo, hi, dbz);
        chk("sdiv_m7_2", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        do_op(-32'sd3, 32'd5, 1'b0, 1'b1, 0, lo, hi, dbz);
        chk("smul_m3_5", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
        do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 0, lo, hi, dbz);
        chk("sdiv_min_m1", {dbz, hi, lo}, {1'b0, 32'h0, 32'h80000000});
`else
        do_op(32'hFFFFFFF9, 32'd2, 1'b1, 1'b1, 0, lo, hi, dbz);
        chk("signed_ignored", {hi, lo}, {32'd1, 32'h7FFFFFFC});
`endif

        // Reset in the middle of CALC, then a fresh op at full latency.
        exp_valid = 1'b0;
        @(negedge clk);
        op_valid = 1'b1;
        op_a     = 32'd5;
        op_b     = 32'd9;
        op_div   = 1'b0;
        @(posedge clk);
        #1 op_valid = 1'b0;
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_flags", {op_ready, res_valid, stall, div_by_zero}, 4'b1000);
        chk("midrst_res", {res_hi, res_lo}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32'd3, 32'd3, 1'b0, 1'b0, 0, lo, hi, dbz);
        chk("mul_3x3_after_rst", {hi, lo}, 64'd9);

        for (int n = 0; n < 40; n++) begin
            logic [DW-1:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFFFFFF;
                3: ra = 32'h80000000;
                default: ;
            endcase
            do_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), lo, hi, dbz);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
